// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one MAC transmit stream between NUM_REQ frame sources.
// Defining ARB_TIMEOUT_EN adds a grant watchdog and the timeout_o pulse output.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests from the round-robin pointer
// XFER  | grant held, owner's stream muxed onto the MAC port
// GAP   | forced inter-frame idle, IFG_CYCLES long
// TERM  | watchdog frame terminator beat (tlast=1, be=0)
module udp_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int IFG_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_user_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  input  logic [NUM_REQ-1:0]     data_vld_i,
  output logic [NUM_REQ-1:0]     data_ready_o,
  input  logic [32*NUM_REQ-1:0]  data_i,
  input  logic [4*NUM_REQ-1:0]   data_be_i,
  input  logic [NUM_REQ-1:0]     data_tlast_i,
  output logic                   mac_tx_data_vld_o,
  input  logic                   mac_tx_data_ready_i,
  output logic [31:0]            mac_tx_data_o,
  output logic [3:0]             mac_tx_data_be_o,
  output logic                   mac_tx_data_tlast_o,
  output logic                   busy_o,
  output logic [2:0]             owner_o
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                   timeout_o
`endif
);

  typedef enum logic [1:0] {IDLE, XFER, GAP, TERM} state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic [7:0]  gap_cnt;
  logic        found;
  logic [2:0]  winner;
  int          cand;
  logic        sel_vld;
  logic [31:0] sel_data;
  logic [3:0]  sel_be;
  logic        sel_tlast;
  logic        fire;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;
`endif

  // First requester at or after the pointer, walking circularly.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && cand == k && req_i[k]) begin
          found  = 1'b1;
          winner = 3'(k);
        end
      end
    end
  end

  always_comb begin
    sel_vld   = 1'b0;
    sel_data  = '0;
    sel_be    = '0;
    sel_tlast = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_o == 3'(k)) begin
        sel_vld   = data_vld_i[k];
        sel_data  = data_i[32*k +: 32];
        sel_be    = data_be_i[4*k +: 4];
        sel_tlast = data_tlast_i[k];
      end
    end
  end

  assign fire   = (state == XFER) && sel_vld && mac_tx_data_ready_i;
  assign busy_o = (state != IDLE);

  always_comb begin
    mac_tx_data_vld_o   = 1'b0;
    mac_tx_data_o       = '0;
    mac_tx_data_be_o    = '0;
    mac_tx_data_tlast_o = 1'b0;
    data_ready_o        = '0;
    if (state == XFER) begin
      mac_tx_data_vld_o   = sel_vld;
      mac_tx_data_o       = sel_data;
      mac_tx_data_be_o    = sel_be;
      mac_tx_data_tlast_o = sel_tlast;
      for (int k = 0; k < NUM_REQ; k++)
        data_ready_o[k] = (owner_o == 3'(k)) && mac_tx_data_ready_i;
    end else if (state == TERM) begin
      mac_tx_data_vld_o   = 1'b1;
      mac_tx_data_tlast_o = 1'b1;
    end
  end

  always_ff @(posedge clk_user_i) begin
    if (reset_i) begin
      state   <= IDLE;
      gnt_o   <= '0;
      owner_o <= '0;
      ptr     <= '0;
      gap_cnt <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            gnt_o   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            owner_o <= winner;
            ptr     <= (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
            state   <= XFER;
`ifdef ARB_TIMEOUT_EN
            wd_cnt  <= '0;
`endif
          end
        end
        XFER: begin
          if (fire && sel_tlast) begin
            gnt_o   <= '0;
            gap_cnt <= '0;
            state   <= (IFG_CYCLES == 0) ? IDLE : GAP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (fire) begin
            wd_cnt <= '0;
          end else if (wd_cnt == WD_LIMIT) begin
            gnt_o     <= '0;
            timeout_o <= 1'b1;
            state     <= TERM;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        GAP: begin
          if (gap_cnt == 8'(IFG_CYCLES - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        TERM: begin
          gap_cnt <= '0;
          state   <= (IFG_CYCLES == 0) ? IDLE : GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: random frame sources, a queue-based round-robin
// model producing expected grant order and MAC beats, and a forked monitor that checks them.
`timescale 1ns/1ps
module tb_udp_tx_arbiter;
  localparam int N   = 3;
  localparam int IFG = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req, gnt, vld, rdy, tlast;
  logic [32*N-1:0] data;
  logic [4*N-1:0]  be;
  logic            mac_vld, mac_rdy, mac_tlast, busy;
  logic [31:0]     mac_data;
  logic [3:0]      mac_be;
  logic [2:0]      owner;

  logic [N-1:0]    req0, gnt0, vld0, rdy0, tlast0;
  logic [32*N-1:0] data0;
  logic [4*N-1:0]  be0;
  logic            mvld0, mrdy0, mtlast0, busy0;
  logic [31:0]     mdata0;
  logic [3:0]      mbe0;
  logic [2:0]      owner0;
`ifdef ARB_TIMEOUT_EN
  logic            timeout, timeout0;
`endif

  udp_tx_arbiter #(.NUM_REQ(N), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(1024)) u_dut (
    .clk_user_i(clk), .reset_i(reset), .req_i(req), .gnt_o(gnt),
    .data_vld_i(vld), .data_ready_o(rdy), .data_i(data), .data_be_i(be), .data_tlast_i(tlast),
    .mac_tx_data_vld_o(mac_vld), .mac_tx_data_ready_i(mac_rdy), .mac_tx_data_o(mac_data),
    .mac_tx_data_be_o(mac_be), .mac_tx_data_tlast_o(mac_tlast), .busy_o(busy), .owner_o(owner)
`ifdef ARB_TIMEOUT_EN
    , .timeout_o(timeout)
`endif
  );

  udp_tx_arbiter #(.NUM_REQ(N), .IFG_CYCLES(0), .TIMEOUT_CYCLES(1024)) u_dut_ifg0 (
    .clk_user_i(clk), .reset_i(reset), .req_i(req0), .gnt_o(gnt0),
    .data_vld_i(vld0), .data_ready_o(rdy0), .data_i(data0), .data_be_i(be0), .data_tlast_i(tlast0),
    .mac_tx_data_vld_o(mvld0), .mac_tx_data_ready_i(mrdy0), .mac_tx_data_o(mdata0),
    .mac_tx_data_be_o(mbe0), .mac_tx_data_tlast_o(mtlast0), .busy_o(busy0), .owner_o(owner0)
`ifdef ARB_TIMEOUT_EN
    , .timeout_o(timeout0)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [36:0] src_q [N][$];   // per-source beats {tlast, be, data}
  int          len_q [N][$];   // per-source frame lengths
  logic [36:0] exp_beats [$];
  int          exp_own [$];
  int          mdl_ptr = 0;
  bit          sb_en = 0;
  int          cyc = 0;
  int          phase_id = 0;
  int          last_tlast_cyc = 0;
  int          last_tlast_phase = -1;
  int          xfers = 0;
  logic [N-1:0] prev_gnt = '0;
  logic         prev_stall = 1'b0;
  logic [31:0]  prev_data = '0;
  logic [3:0]   prev_be = '0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (src_q[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic gen_frames(input int k, input int nfr, input int minlen, input int maxlen);
    int len;
    for (int f = 0; f < nfr; f++) begin
      len = $urandom_range(maxlen, minlen);
      len_q[k].push_back(len);
      for (int j = 0; j < len; j++)
        src_q[k].push_back({(j == len - 1), 4'($urandom), 32'($urandom)});
    end
  endtask

  // Round-robin over sources that still hold frames; each grant emits a whole frame.
  task automatic arbitrate_model();
    int off [N];
    int w, c, len;
    bit done;
    for (int k = 0; k < N; k++) off[k] = 0;
    done = 1'b0;
    while (!done) begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        c = (mdl_ptr + i) % N;
        if (w < 0 && len_q[c].size() > 0) w = c;
      end
      if (w < 0) done = 1'b1;
      else begin
        len = len_q[w].pop_front();
        exp_own.push_back(w);
        for (int j = 0; j < len; j++) exp_beats.push_back(src_q[w][off[w] + j]);
        off[w] += len;
        mdl_ptr = (w + 1) % N;
      end
    end
  endtask

  task automatic monitor();
    logic [36:0] eb;
    int e, d;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_en) begin
        if (prev_gnt == '0 && gnt != '0) begin
          if (exp_own.size() == 0) chk(1'b0, "unexpected_grant", 64'(gnt), 64'(0));
          else begin
            e = exp_own.pop_front();
            chk(gnt == (3'b001 << e), "grant", 64'(gnt), 64'(3'b001 << e));
            chk(owner == 3'(e), "owner", 64'(owner), 64'(e));
            if (last_tlast_phase == phase_id)
              chk(cyc - last_tlast_cyc == IFG + 2, "grant_spacing", 64'(cyc - last_tlast_cyc), 64'(IFG + 2));
          end
        end
        if (last_tlast_phase == phase_id) begin
          d = cyc - last_tlast_cyc;
          if (d >= 1 && d <= IFG) chk(busy && gnt == '0, "gap_state", 64'({busy, gnt}), 64'({1'b1, 3'b000}));
          if (d == IFG + 1) chk(!busy, "idle_after_gap", 64'(busy), 64'(0));
        end
        if (gnt == '0)
          chk(!mac_vld && !mac_tlast && mac_be == 4'h0 && mac_data == 32'h0 && rdy == '0, "mac_quiet",
              64'({rdy, mac_vld, mac_tlast, mac_be, mac_data}), 64'(0));
        else begin
          chk(rdy == (gnt & {N{mac_rdy}}), "data_ready", 64'(rdy), 64'(gnt & {N{mac_rdy}}));
          if (prev_stall && gnt == prev_gnt)
            chk(mac_vld && mac_data == prev_data && mac_be == prev_be, "stall_hold", 64'(mac_data), 64'(prev_data));
        end
        if (mac_vld && mac_rdy) begin
          xfers++;
          if (exp_beats.size() == 0) chk(1'b0, "unexpected_beat", 64'({mac_tlast, mac_be, mac_data}), 64'(0));
          else begin
            eb = exp_beats.pop_front();
            chk({mac_tlast, mac_be, mac_data} == eb, "beat", 64'({mac_tlast, mac_be, mac_data}), 64'(eb));
          end
          if (mac_tlast) begin
            last_tlast_cyc   = cyc;
            last_tlast_phase = phase_id;
          end
        end
      end
      prev_gnt   = gnt;
      prev_stall = mac_vld && !mac_rdy;
      prev_data  = mac_data;
      prev_be    = mac_be;
    end
  endtask

  task automatic drive_sources(input int rmode, input int vmode, input logic [N-1:0] fired);
    logic [36:0] b;
    for (int k = 0; k < N; k++) begin
      req[k] = (src_q[k].size() > 0);
      if (gnt[k] && src_q[k].size() > 0) begin
        b = src_q[k][0];
        data[32*k +: 32] = b[31:0];
        be[4*k +: 4]     = b[35:32];
        tlast[k]         = b[36];
        // a valid beat that has not transferred stays asserted
        if (!(vld[k] && !fired[k])) vld[k] = (vmode == 0) ? 1'b1 : ($urandom_range(3) != 0);
      end else begin
        vld[k]           = 1'($urandom);
        data[32*k +: 32] = $urandom;
        be[4*k +: 4]     = 4'($urandom);
        tlast[k]         = 1'($urandom);
      end
    end
    case (rmode)
      0:       mac_rdy = 1'b1;
      1:       mac_rdy = !mac_rdy;
      default: mac_rdy = ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic run_phase(input int rmode, input int vmode);
    logic [N-1:0] fired;
    int budget;
    phase_id++;
    xfers = 0;
    sb_en = 1'b1;
    arbitrate_model();
    fired = '0;
    drive_sources(rmode, vmode, fired);
    budget = 0;
    while ((pending() || busy) && budget < 3000) begin
      @(negedge clk);
      fired = vld & rdy;
      @(posedge clk); #1;
      budget++;
      for (int k = 0; k < N; k++)
        if (fired[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      drive_sources(rmode, vmode, fired);
    end
    req = '0; vld = '0; tlast = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(budget < 3000, "phase_budget", 64'(budget), 64'(3000));
    chk(exp_beats.size() == 0 && exp_own.size() == 0, "phase_drain",
        64'(exp_beats.size() + exp_own.size()), 64'(0));
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_beats.delete();
    exp_own.delete();
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    reset = 1'b1;
    req = '0; vld = '0; data = '0; be = '0; tlast = '0; mac_rdy = 1'b0;
    req0 = '0; vld0 = '0; data0 = '0; be0 = '0; tlast0 = '0; mrdy0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mdl_ptr = 0;
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      len_q[k].delete();
    end
    exp_beats.delete();
    exp_own.delete();
  endtask

  task automatic ifg0_test();
    int t1, t2, t2x;
    logic [31:0] d1, d2;
    do_reset();
    data0  = {32'hB2B2_0002, 32'hA1A1_0001, 32'h0};
    be0    = {4'hC, 4'h3, 4'h0};
    tlast0 = 3'b110;
    vld0   = 3'b110;
    req0   = 3'b110;
    mrdy0  = 1'b1;
    t1 = -1; t2 = -1; t2x = -1; d1 = '0; d2 = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (t1 < 0 && gnt0 == 3'b010 && mvld0 && mrdy0) begin t1 = c; d1 = mdata0; end
      if (t2 < 0 && gnt0 == 3'b100) t2 = c;
      if (t2x < 0 && gnt0 == 3'b100 && mvld0 && mrdy0) begin t2x = c; d2 = mdata0; end
      @(posedge clk); #1;
      if (t1 >= 0) begin req0[1] = 1'b0; vld0[1] = 1'b0; end
      if (t2x >= 0) begin req0[2] = 1'b0; vld0[2] = 1'b0; end
    end
    chk(t1 >= 0 && t2 - t1 == 2, "ifg0_spacing", 64'(t2 - t1), 64'(2));
    chk(d1 == 32'hA1A1_0001, "ifg0_beat_src1", 64'(d1), 64'(32'hA1A1_0001));
    chk(d2 == 32'hB2B2_0002, "ifg0_beat_src2", 64'(d2), 64'(32'hB2B2_0002));
    chk(owner0 == 3'd2 && !busy0 && gnt0 == '0, "ifg0_end", 64'({owner0, busy0, gnt0}), 64'({3'd2, 1'b0, 3'b000}));
  endtask

  initial begin
    int n, t;
    reset = 1'b1;
    fork
      monitor();
    join_none

    do_reset();
    chk(gnt == '0, "reset_gnt", 64'(gnt), 64'(0));
    chk(owner == 3'd0 && !busy, "reset_owner_busy", 64'({owner, busy}), 64'(0));
    chk(!mac_vld && !mac_tlast && mac_data == 32'h0 && mac_be == 4'h0, "reset_mac",
        64'({mac_vld, mac_tlast, mac_be, mac_data}), 64'(0));
    chk(rdy == '0, "reset_ready", 64'(rdy), 64'(0));
    chk(gnt0 == '0 && !busy0, "reset_ifg0", 64'({gnt0, busy0}), 64'(0));

    // single 16-beat ARP frame, MAC always ready
    gen_frames(0, 1, 16, 16);
    run_phase(0, 0);
    chk(xfers == 16, "arp_16_beats", 64'(xfers), 64'(16));

    // all three sources requesting, 2-beat frames
    do_reset();
    for (int k = 0; k < N; k++) gen_frames(k, 2, 2, 2);
    run_phase(0, 0);
    chk(xfers == 12, "rr_beats", 64'(xfers), 64'(12));

    // MAC ready toggling 1,0,1,0
    do_reset();
    gen_frames(1, 1, 16, 16);
    run_phase(1, 0);
    chk(xfers == 16, "toggle_xfers", 64'(xfers), 64'(16));

    // reset in the middle of a UDP frame
    do_reset();
    req = 3'b100; vld = 3'b100; tlast = 3'b000; data[95:64] = 32'hC0DE_0000; be[11:8] = 4'hF; mac_rdy = 1'b1;
    n = 0; t = 0;
    while (n < 5 && t < 40) begin
      @(negedge clk);
      t++;
      if (mac_vld && mac_rdy) n++;
      @(posedge clk); #1;
      data[95:64] = data[95:64] + 32'd1;
    end
    chk(n == 5, "midreset_prep", 64'(n), 64'(5));
    reset = 1'b1;
    @(posedge clk); #1;
    chk(gnt == '0 && !mac_vld && !mac_tlast, "midreset_outputs", 64'({gnt, mac_vld, mac_tlast}), 64'(0));
    chk(owner == 3'd0 && !busy, "midreset_owner_busy", 64'({owner, busy}), 64'(0));
    reset = 1'b0;
    req = '0; vld = '0; data = '0; be = '0;
    mdl_ptr = 0;
    gen_frames(2, 1, 1, 4);
    run_phase(0, 0);

    ifg0_test();

    // randomized traffic
    do_reset();
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < N; k++) gen_frames(k, $urandom_range(3, 0), 1, 6);
      run_phase(2, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
